// File: rtl/prog_launcher.sv
// Harness-side sequencer: launches NPROG CPU programs back to back via Start,
// measures RUN cycles until Done, and flags programs that hit TIMEOUT.
module prog_launcher #(
    parameter int NPROG     = 3,
    parameter int PW        = 2,
    parameter int START_CYC = 2,
    parameter int CW        = 16,
    parameter int TIMEOUT   = 1000
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Go,
    input  logic          Done,
    output logic          Start,
    output logic [PW-1:0] ProgIdx,
    output logic          Busy,
    output logic [CW-1:0] CycleCount,
    output logic          CountValid,
    output logic          TimedOut,
    output logic          AllDone,
    output logic [2:0]    DbgState
);

    // Go and Done are plain levels with no back-pressure: Go is sampled only in
    // IDLE, Done only from the second RUN cycle; both are ignored elsewhere.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RUN    = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam int HW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_CYC - 1);
    localparam logic [CW-1:0] RUN_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] RUN_FIRST = CW'(1);
    localparam logic [PW-1:0] LAST_IDX  = PW'(NPROG - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] run_q, run_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [CW-1:0] cc_q, cc_d;
    logic          cv_q, cv_d;
    logic          to_q, to_d;
    logic          ad_q, ad_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          complete;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        run_d    = run_q;
        idx_d    = idx_q;
        cc_d     = cc_q;
        cv_d     = 1'b0;
        to_d     = to_q;
        ad_d     = 1'b0;
        complete = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    state_d = S_START;
                    idx_d   = '0;
                    to_d    = 1'b0;
                    hold_d  = '0;
                end
            end

            S_START: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    run_d   = RUN_FIRST;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            S_RUN: begin
                // A lingering Done from the previous program is masked in cycle 1;
                // Done wins over timeout when both land on the last allowed cycle.
                if (run_q != RUN_FIRST && Done) begin
                    complete = 1'b1;
                end else if (run_q == RUN_LIMIT) begin
                    complete = 1'b1;
                    to_d     = 1'b1;
                end else begin
                    run_d = run_q + RUN_FIRST;
                end

                if (complete) begin
                    cc_d = run_q;
                    cv_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + PW'(1);
                        state_d = S_GAP;
                    end
                end
            end

            S_GAP: begin
                state_d = S_START;
                hold_d  = '0;
            end

            S_FINISH: begin
                // First FINISH cycle carries the final CountValid, second one AllDone.
                if (ad_q) begin
                    state_d = S_IDLE;
                end else begin
                    ad_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            run_q   <= '0;
            idx_q   <= '0;
            cc_q    <= '0;
            cv_q    <= 1'b0;
            to_q    <= 1'b0;
            ad_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            run_q   <= run_d;
            idx_q   <= idx_d;
            cc_q    <= cc_d;
            cv_q    <= cv_d;
            to_q    <= to_d;
            ad_q    <= ad_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign Start      = start_q;
    assign ProgIdx    = idx_q;
    assign Busy       = busy_q;
    assign CycleCount = cc_q;
    assign CountValid = cv_q;
    assign TimedOut   = to_q;
    assign AllDone    = ad_q;
    assign DbgState   = state_q;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: normal runs, lingering Done, timeout,
// Done on the timeout cycle, ignored Go pulses and mid-run asynchronous reset.
module tb_prog_launcher;

    localparam int NPROG     = 3;
    localparam int PW        = 2;
    localparam int START_CYC = 2;
    localparam int CW        = 16;
    localparam int TIMEOUT   = 20;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    logic          Clk;
    logic          Reset_n;
    logic          Go;
    logic          Done;
    logic          Start;
    logic [PW-1:0] ProgIdx;
    logic          Busy;
    logic [CW-1:0] CycleCount;
    logic          CountValid;
    logic          TimedOut;
    logic          AllDone;
    logic [2:0]    DbgState;

    int errors = 0;
    int checks = 0;
    bit done_hold = 1'b0;
    bit go_noise  = 1'b0;

    prog_launcher #(
        .NPROG(NPROG), .PW(PW), .START_CYC(START_CYC), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .Done(Done),
        .Start(Start), .ProgIdx(ProgIdx), .Busy(Busy),
        .CycleCount(CycleCount), .CountValid(CountValid),
        .TimedOut(TimedOut), .AllDone(AllDone), .DbgState(DbgState)
    );

    // clock / reset block
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse Go from IDLE; returns in the first START cycle.
    task automatic launch();
        Go = 1'b1;
        step();
        Go = go_noise;
    endtask

    // Starts in the first START cycle of program idx, ends in the cycle after completion.
    task automatic run_prog(input int idx, input int exp_cc, input bit use_done, input bit exp_to);
        chk("start_hi1", 32'(Start), 32'd1);
        chk("busy_start", 32'(Busy), 32'd1);
        chk("idx_start", 32'(ProgIdx), 32'(idx));
        chk("state_start", 32'(DbgState), 32'(ST_START));
        step();
        chk("start_hi2", 32'(Start), 32'd1);
        step();
        chk("start_fall", 32'(Start), 32'd0);
        chk("state_run", 32'(DbgState), 32'(ST_RUN));
        for (int c = 1; c < exp_cc; c++) step();
        chk("cv_pre", 32'(CountValid), 32'd0);
        chk("to_pre", 32'(TimedOut), (idx == 0) ? 32'd0 : 32'(exp_to));
        if (use_done && !done_hold) Done = 1'b1;
        step();
        if (!done_hold) Done = 1'b0;
        chk("cv_pulse", 32'(CountValid), 32'd1);
        chk("cycle_count", 32'(CycleCount), 32'(exp_cc));
        chk("timed_out", 32'(TimedOut), 32'(exp_to));
    endtask

    task automatic after_prog(input int idx, input bit last);
        if (!last) begin
            chk("state_gap", 32'(DbgState), 32'(ST_GAP));
            chk("idx_next", 32'(ProgIdx), 32'(idx + 1));
            chk("start_gap", 32'(Start), 32'd0);
            chk("busy_gap", 32'(Busy), 32'd1);
            step();
        end else begin
            chk("state_finish", 32'(DbgState), 32'(ST_FINISH));
            chk("idx_last", 32'(ProgIdx), 32'(NPROG - 1));
            chk("alldone_early", 32'(AllDone), 32'd0);
            step();
            chk("alldone", 32'(AllDone), 32'd1);
            chk("cv_after", 32'(CountValid), 32'd0);
            chk("busy_alldone", 32'(Busy), 32'd1);
            step();
            chk("alldone_off", 32'(AllDone), 32'd0);
            chk("busy_off", 32'(Busy), 32'd0);
            chk("state_idle", 32'(DbgState), 32'(ST_IDLE));
            chk("idx_hold", 32'(ProgIdx), 32'(NPROG - 1));
        end
    endtask

    task automatic full_run(input int exp_cc, input bit use_done, input bit exp_to);
        for (int p = 0; p < NPROG; p++) begin
            run_prog(p, exp_cc, use_done, exp_to);
            after_prog(p, p == NPROG - 1);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Go      = 1'b0;
        Done    = 1'b0;
        #3;
        chk("rst_start", 32'(Start), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_idx", 32'(ProgIdx), 32'd0);
        chk("rst_cc", 32'(CycleCount), 32'd0);
        chk("rst_cv", 32'(CountValid), 32'd0);
        chk("rst_to", 32'(TimedOut), 32'd0);
        chk("rst_ad", 32'(AllDone), 32'd0);
        chk("rst_state", 32'(DbgState), 32'(ST_IDLE));
        step();
        step();
        Reset_n = 1'b1;
        step();
        chk("idle_busy", 32'(Busy), 32'd0);

        // Done in RUN cycle 10 for every program
        launch();
        full_run(10, 1'b1, 1'b0);

        // Done stuck high: cycle 1 masked, each program completes in cycle 2
        Done = 1'b1;
        done_hold = 1'b1;
        step();
        launch();
        full_run(2, 1'b1, 1'b0);
        done_hold = 1'b0;
        Done = 1'b0;

        // Done never arrives: every program times out at 20
        launch();
        full_run(TIMEOUT, 1'b0, 1'b1);
        chk("to_sticky", 32'(TimedOut), 32'd1);

        // New Go clears TimedOut; Done on exactly the timeout cycle is a normal finish
        launch();
        chk("to_cleared", 32'(TimedOut), 32'd0);
        full_run(TIMEOUT, 1'b1, 1'b0);

        // Go held through START/RUN/GAP/FINISH is ignored; held into IDLE it relaunches
        go_noise = 1'b1;
        launch();
        full_run(4, 1'b1, 1'b0);
        step();
        go_noise = 1'b0;
        Go = 1'b0;
        chk("relaunch_idx", 32'(ProgIdx), 32'd0);
        chk("relaunch_start", 32'(Start), 32'd1);

        // Async reset in RUN of program 1 discards the run
        run_prog(0, 5, 1'b1, 1'b0);
        after_prog(0, 1'b0);
        step();
        step();
        step();
        step();
        chk("mid_run_state", 32'(DbgState), 32'(ST_RUN));
        chk("mid_run_idx", 32'(ProgIdx), 32'd1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_start", 32'(Start), 32'd0);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_idx", 32'(ProgIdx), 32'd0);
        chk("arst_cc", 32'(CycleCount), 32'd0);
        step();
        Reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            Done = c[0];
            step();
            chk("post_rst_cv", 32'(CountValid), 32'd0);
            chk("post_rst_ad", 32'(AllDone), 32'd0);
            chk("post_rst_busy", 32'(Busy), 32'd0);
        end
        Done = 1'b0;
        launch();
        full_run(10, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
